// File: rtl/vt52_pkg.sv
// Shared VT52 constants: ASCII control bytes, escape letters, handler states, screen defaults.
package vt52_pkg;
  localparam int ROWS_DEF = 24;
  localparam int COLS_DEF = 80;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_ESC   = 8'h1B;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  localparam logic [7:0] ESC_UP    = 8'h41;  // A
  localparam logic [7:0] ESC_DOWN  = 8'h42;  // B
  localparam logic [7:0] ESC_RIGHT = 8'h43;  // C
  localparam logic [7:0] ESC_LEFT  = 8'h44;  // D
  localparam logic [7:0] ESC_HOME  = 8'h48;  // H
  localparam logic [7:0] ESC_EOS   = 8'h4A;  // J
  localparam logic [7:0] ESC_EOL   = 8'h4B;  // K
  localparam logic [7:0] ESC_POS   = 8'h59;  // Y

  localparam logic [2:0] ST_NORMAL = 3'd0;
  localparam logic [2:0] ST_ESC    = 3'd1;
  localparam logic [2:0] ST_Y_ROW  = 3'd2;
  localparam logic [2:0] ST_Y_COL  = 3'd3;
  localparam logic [2:0] ST_CLEAR  = 3'd4;
endpackage

// File: rtl/clear_filler.sv
// Walks an address range one location per cycle starting the cycle after start_i.
// busy_o doubles as the write strobe; done_o flags the final write.
module clear_filler #(
  parameter int ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [ADDR_BITS-1:0] start_addr_i,
  input  logic [ADDR_BITS-1:0] end_addr_i,
  output logic                 busy_o,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic                 done_o
);
  logic                 busy_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [ADDR_BITS-1:0] end_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      addr_q <= '0;
      end_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      addr_q <= start_addr_i;
      end_q  <= end_addr_i;
    end else if (busy_q) begin
      if (addr_q == end_q) busy_q <= 1'b0;
      else                 addr_q <= addr_q + ADDR_BITS'(1);
    end
  end

  assign busy_o = busy_q;
  assign addr_o = addr_q;
  assign done_o = busy_q && (addr_q == end_q);
endmodule

// File: rtl/command_handler.sv
// VT52 byte interpreter: decodes controls/escapes into registered cursor and character writes.
// One ready bubble after every cursor write so the cursor block's feedback is fresh.
module command_handler
  import vt52_pkg::*;
#(
  parameter int ROW_BITS  = 5,
  parameter int COL_BITS  = 7,
  parameter int ROWS      = ROWS_DEF,
  parameter int COLS      = COLS_DEF,
  parameter int ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           data,
  input  logic                 valid,
  output logic                 ready,
  input  logic [COL_BITS-1:0]  cursor_x,
  input  logic [ROW_BITS-1:0]  cursor_y,
  output logic [COL_BITS-1:0]  new_cursor_x,
  output logic [ROW_BITS-1:0]  new_cursor_y,
  output logic                 new_cursor_wen,
  output logic [7:0]           new_char,
  output logic [ADDR_BITS-1:0] new_char_address,
  output logic                 new_char_wen,
  output logic                 scroll_req
);
  localparam logic [COL_BITS-1:0] XMAX = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] YMAX = ROW_BITS'(ROWS - 1);

  logic [2:0]           state_q, state_d;
  logic [ROW_BITS-1:0]  row_q, row_d;
  logic                 row_ok_q, row_ok_d;
  logic [COL_BITS-1:0]  ncx_q, ncx_d;
  logic [ROW_BITS-1:0]  ncy_q, ncy_d;
  logic                 cwen_q, cwen_d;
  logic                 chwen_q, chwen_d;
  logic [7:0]           ch_q, ch_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 scroll_q, scroll_d;
  logic                 ready_q, ready_d;

  logic                 accept;
  logic [7:0]           off;
  logic                 in_rows, in_cols;
  logic [COL_BITS:0]    tab_x;
  logic [ADDR_BITS-1:0] row_base, cur_addr;
  logic                 fill_start, fill_busy, fill_done;
  logic [ADDR_BITS-1:0] fill_end, fill_addr;

  assign accept   = valid && ready;
  // Bytes below 0x20 must not wrap into range after the bias is removed.
  assign off      = data - CH_SPACE;
  assign in_rows  = (data >= CH_SPACE) && (off < 8'(ROWS));
  assign in_cols  = (data >= CH_SPACE) && (off < 8'(COLS));
  assign tab_x    = {1'b0, cursor_x | COL_BITS'(7)} + (COL_BITS+1)'(1);
  assign row_base = ADDR_BITS'(cursor_y) * ADDR_BITS'(COLS);
  assign cur_addr = row_base + ADDR_BITS'(cursor_x);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    row_ok_d   = row_ok_q;
    ncx_d      = ncx_q;
    ncy_d      = ncy_q;
    cwen_d     = 1'b0;
    chwen_d    = 1'b0;
    ch_d       = ch_q;
    addr_d     = addr_q;
    scroll_d   = 1'b0;
    fill_start = 1'b0;
    fill_end   = row_base + ADDR_BITS'(COLS - 1);
    case (state_q)
      ST_NORMAL: if (accept) begin
        ncx_d = cursor_x;
        ncy_d = cursor_y;
        if (data >= CH_SPACE && data <= CH_TILDE) begin
          chwen_d = 1'b1;
          ch_d    = data;
          addr_d  = cur_addr;
          cwen_d  = 1'b1;
          ncx_d   = (cursor_x == XMAX) ? XMAX : cursor_x + COL_BITS'(1);
        end else begin
          case (data)
            CH_CR:  begin cwen_d = 1'b1; ncx_d = '0; end
            CH_LF:  if (cursor_y == YMAX) scroll_d = 1'b1;
                    else begin cwen_d = 1'b1; ncy_d = cursor_y + ROW_BITS'(1); end
            CH_BS:  begin cwen_d = 1'b1; if (cursor_x != '0) ncx_d = cursor_x - COL_BITS'(1); end
            CH_TAB: begin
              cwen_d = 1'b1;
              ncx_d  = (tab_x > {1'b0, XMAX}) ? XMAX : tab_x[COL_BITS-1:0];
            end
            CH_ESC: state_d = ST_ESC;
            default: ;
          endcase
        end
      end
      ST_ESC: if (accept) begin
        state_d = ST_NORMAL;
        ncx_d   = cursor_x;
        ncy_d   = cursor_y;
        case (data)
          ESC_UP:    begin cwen_d = 1'b1; if (cursor_y != '0) ncy_d = cursor_y - ROW_BITS'(1); end
          ESC_DOWN:  begin cwen_d = 1'b1; if (cursor_y != YMAX) ncy_d = cursor_y + ROW_BITS'(1); end
          ESC_RIGHT: begin cwen_d = 1'b1; if (cursor_x != XMAX) ncx_d = cursor_x + COL_BITS'(1); end
          ESC_LEFT:  begin cwen_d = 1'b1; if (cursor_x != '0) ncx_d = cursor_x - COL_BITS'(1); end
          ESC_HOME:  begin cwen_d = 1'b1; ncx_d = '0; ncy_d = '0; end
          ESC_EOS:   begin fill_start = 1'b1; fill_end = ADDR_BITS'(ROWS * COLS - 1); state_d = ST_CLEAR; end
          ESC_EOL:   begin fill_start = 1'b1; state_d = ST_CLEAR; end
          ESC_POS:   state_d = ST_Y_ROW;
          CH_ESC:    state_d = ST_ESC;
          default: ;
        endcase
      end
      ST_Y_ROW: if (accept) begin
        row_d    = off[ROW_BITS-1:0];
        row_ok_d = in_rows;
        state_d  = ST_Y_COL;
      end
      ST_Y_COL: if (accept) begin
        cwen_d  = 1'b1;
        ncx_d   = in_cols ? off[COL_BITS-1:0] : cursor_x;
        ncy_d   = row_ok_q ? row_q : cursor_y;
        state_d = ST_NORMAL;
      end
      ST_CLEAR: if (fill_done) state_d = ST_NORMAL;
      default: state_d = ST_NORMAL;
    endcase
    ready_d = !cwen_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_NORMAL;
      row_q    <= '0;
      row_ok_q <= 1'b0;
      ncx_q    <= '0;
      ncy_q    <= '0;
      cwen_q   <= 1'b0;
      chwen_q  <= 1'b0;
      ch_q     <= '0;
      addr_q   <= '0;
      scroll_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      row_ok_q <= row_ok_d;
      ncx_q    <= ncx_d;
      ncy_q    <= ncy_d;
      cwen_q   <= cwen_d;
      chwen_q  <= chwen_d;
      ch_q     <= ch_d;
      addr_q   <= addr_d;
      scroll_q <= scroll_d;
      ready_q  <= ready_d;
    end
  end

  clear_filler #(.ADDR_BITS(ADDR_BITS)) u_fill (
    .clk          (clk),
    .reset        (reset),
    .start_i      (fill_start),
    .start_addr_i (cur_addr),
    .end_addr_i   (fill_end),
    .busy_o       (fill_busy),
    .addr_o       (fill_addr),
    .done_o       (fill_done)
  );

  assign ready            = ready_q && (state_q != ST_CLEAR);
  assign new_cursor_x     = ncx_q;
  assign new_cursor_y     = ncy_q;
  assign new_cursor_wen   = cwen_q;
  assign new_char_wen     = chwen_q | fill_busy;
  assign new_char         = fill_busy ? CH_SPACE : ch_q;
  assign new_char_address = fill_busy ? fill_addr : addr_q;
  assign scroll_req       = scroll_q;
endmodule

// File: tb/tb_command_handler.sv
// Directed bench for command_handler; the cursor block is modelled by looping cursor writes back.
module tb_command_handler;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic [6:0]  new_cursor_x;
  logic [4:0]  new_cursor_y;
  logic        new_cursor_wen;
  logic [7:0]  new_char;
  logic [10:0] new_char_address;
  logic        new_char_wen;
  logic        scroll_req;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  command_handler dut (
    .clk              (clk),
    .reset            (reset),
    .data             (data),
    .valid            (valid),
    .ready            (ready),
    .cursor_x         (cursor_x),
    .cursor_y         (cursor_y),
    .new_cursor_x     (new_cursor_x),
    .new_cursor_y     (new_cursor_y),
    .new_cursor_wen   (new_cursor_wen),
    .new_char         (new_char),
    .new_char_address (new_char_address),
    .new_char_wen     (new_char_wen),
    .scroll_req       (scroll_req)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    @(negedge clk);
    n = 0;
    while (ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) chk("ready_timeout", 32'(ready), 32'd1);
    data  = b;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    data  = 8'h00;
    if (new_cursor_wen === 1'b1) begin
      cursor_x = new_cursor_x;
      cursor_y = new_cursor_y;
    end
  endtask

  task automatic quiet(input string tag);
    chk({tag, "_cwen"}, 32'(new_cursor_wen), 32'd0);
    chk({tag, "_chwen"}, 32'(new_char_wen), 32'd0);
    chk({tag, "_scroll"}, 32'(scroll_req), 32'd0);
  endtask

  task automatic cur(input string tag, input int x, input int y);
    chk({tag, "_cwen"}, 32'(new_cursor_wen), 32'd1);
    chk({tag, "_x"}, 32'(new_cursor_x), 32'(x));
    chk({tag, "_y"}, 32'(new_cursor_y), 32'(y));
  endtask

  task automatic goto(input string tag, input int x, input int y);
    send(8'h1B); send(8'h59); send(8'(y + 32)); send(8'(x + 32));
    cur(tag, x, y);
  endtask

  initial begin
    int n;
    int bad;
    reset = 1'b1; valid = 1'b0; data = 8'h00; cursor_x = '0; cursor_y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    quiet("rst");
    chk("rst_cx", 32'(new_cursor_x), 32'd0);
    chk("rst_cy", 32'(new_cursor_y), 32'd0);
    chk("rst_char", 32'(new_char), 32'd0);
    chk("rst_addr", 32'(new_char_address), 32'd0);
    @(negedge clk); reset = 1'b0;

    send(8'h41);
    chk("A_chwen", 32'(new_char_wen), 32'd1);
    chk("A_char", 32'(new_char), 32'h41);
    chk("A_addr", 32'(new_char_address), 32'd0);
    cur("A", 1, 0);
    chk("A_bubble", 32'(ready), 32'd0);
    step();
    quiet("A_next");
    chk("A_ready_back", 32'(ready), 32'd1);
    send(8'h42);
    chk("B_char", 32'(new_char), 32'h42);
    chk("B_addr", 32'(new_char_address), 32'd1);
    cur("B", 2, 0);
    chk("B_bubble", 32'(ready), 32'd0);

    send(8'h1B); quiet("escY_esc"); chk("escY_esc_rdy", 32'(ready), 32'd1);
    send(8'h59); quiet("escY_Y");
    send(8'h25); quiet("escY_row");
    send(8'h2A); cur("escY", 10, 5);
    send(8'h1B); send(8'h59); send(8'h40); send(8'h21); cur("escY_oor", 1, 5);
    send(8'h1B); send(8'h59); send(8'h05); send(8'h10); cur("escY_under", 1, 5);

    goto("goto_corner", 79, 23);
    send(8'h58);
    chk("X_addr", 32'(new_char_address), 32'd1919);
    chk("X_chwen", 32'(new_char_wen), 32'd1);
    cur("X", 79, 23);
    send(8'h0A);
    chk("LF_scroll", 32'(scroll_req), 32'd1);
    chk("LF_cwen", 32'(new_cursor_wen), 32'd0);
    chk("LF_ready", 32'(ready), 32'd1);
    step();
    chk("LF_scroll_off", 32'(scroll_req), 32'd0);
    send(8'h1B); send(8'h43); cur("escC_edge", 79, 23);

    goto("goto_70_3", 70, 3);
    send(8'h1B); send(8'h4B);
    chk("K_first_wen", 32'(new_char_wen), 32'd1);
    n = 0; bad = 0;
    while (new_char_wen === 1'b1 && n < 100) begin
      if (new_char_address !== 11'(310 + n) || new_char !== 8'h20 || ready !== 1'b0 || new_cursor_wen !== 1'b0) bad++;
      n++;
      step();
    end
    chk("K_writes", 32'(n), 32'd10);
    chk("K_bad", 32'(bad), 32'd0);
    chk("K_ready_after", 32'(ready), 32'd1);
    send(8'h09); cur("TAB70", 72, 3);
    send(8'h0D); cur("CR", 0, 3);
    send(8'h09); cur("TAB0", 8, 3);
    goto("goto_76_3", 76, 3);
    send(8'h09); cur("TAB76", 79, 3);

    send(8'h1B); send(8'h48); cur("escH", 0, 0);
    send(8'h1B); send(8'h4A);
    n = 0; bad = 0;
    while (new_char_wen === 1'b1 && n < 2500) begin
      if (new_char_address !== 11'(n) || ready !== 1'b0) bad++;
      n++;
      step();
    end
    chk("J_writes", 32'(n), 32'd1920);
    chk("J_bad", 32'(bad), 32'd0);
    chk("J_ready_after", 32'(ready), 32'd1);

    send(8'h1B); send(8'h4A);
    n = 0;
    while (new_char_wen === 1'b1 && n < 500) begin
      n++;
      step();
    end
    chk("Jrst_reached", 32'(n), 32'd500);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("Jrst_wen", 32'(new_char_wen), 32'd0);
    chk("Jrst_ready", 32'(ready), 32'd1);
    @(negedge clk); reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (new_char_wen !== 1'b0) bad++;
    end
    chk("Jrst_no_more", 32'(bad), 32'd0);

    send(8'h1B); quiet("escQ_esc");
    send(8'h51); quiet("escQ_Q"); chk("escQ_ready", 32'(ready), 32'd1);
    send(8'h5A);
    chk("Z_chwen", 32'(new_char_wen), 32'd1);
    chk("Z_char", 32'(new_char), 32'h5A);
    chk("Z_addr", 32'(new_char_address), 32'd0);
    cur("Z", 1, 0);
    send(8'h08); cur("BS1", 0, 0);
    send(8'h08); cur("BS0", 0, 0);
    send(8'h07); quiet("ignored_bel");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
